// File: rtl/dbg_cmd_pkg.sv
// dbg_cmd_pkg
// Shared definitions for the sysclk-side JTAG debug command receiver.
//   DATA_W_DEF, IR_W_DEF, ACTION_BIT_DEF : default widths / action bit position
//   cmd_entry_t : queued command layout {ir, payload} at the default widths
//   onehot_ir() : one bit of the one-hot decode of an IR value
package dbg_cmd_pkg;

   localparam int DATA_W_DEF     = 38;
   localparam int IR_W_DEF       = 2;
   localparam int ACTION_BIT_DEF = 34;

   typedef struct packed {
      logic [IR_W_DEF-1:0]   ir;
      logic [DATA_W_DEF-1:0] payload;
   } cmd_entry_t;

   // Returns bit ch of onehot(ir); used per channel so it works for any IR width.
   function automatic logic onehot_ir(input int ir, input int ch);
      return (ir == ch);
   endfunction

endpackage

// File: rtl/dbg_strobe_sync.sv
// dbg_strobe_sync
// Synchronises one asynchronous TCK-domain strobe into clk and reports its
// rising edge as a single-cycle pulse.
//   clk     : system clock
//   reset   : synchronous, active-high
//   i_async : asynchronous strobe level
//   o_rise  : one-cycle pulse on a synchronised rising edge
module dbg_strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_rise
);

   // Edges are suppressed until the chain has been reloaded after reset and
   // r_prev has caught up, so a strobe held high through reset is not
   // mistaken for a new one.
   localparam int BLANK = SYNC_STAGES + 1;
   localparam int BW    = $clog2(BLANK + 1);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;
   logic [BW-1:0]          r_blank;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= '0;
         r_prev  <= 1'b0;
         r_blank <= BW'(BLANK);
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
         r_prev  <= r_chain[SYNC_STAGES-1];
         if (r_blank != '0)
            r_blank <= r_blank - BW'(1);
      end
   end

   assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev & (r_blank == '0);

endmodule

// File: rtl/dbg_cmd_sysclk_gen.sv
// dbg_cmd_sysclk_gen
// Sysclk-side command receiver for the CPU JTAG debug module. Update-IR
// latches the instruction, update-DR queues {ir_cur, sr} in a small FIFO that
// is presented first-word-fall-through with a one-hot channel decode.
// Optional feature macro: DBG_CMD_DROP_CNT_EN adds drop_cnt[7:0], a saturating
// count of dropped commands.
//   clk, reset           : system clock, synchronous active-high reset
//   vs_uir, vs_udr       : async TCK-domain update-IR / update-DR levels
//   ir_in, sr            : quasi-static TCK-domain IR and shift register
//   cmd_ready            : consumer takes the head command
//   ovf_clr              : clears overflow (and drop_cnt)
//   jdo, cmd_valid       : head payload / FIFO non-empty
//   cmd_sel, cmd_action  : one-hot head IR / head action bit, both gated by valid
//   ir_update, ir_cur    : IR latch pulse and value
//   level, overflow      : occupancy and sticky drop flag
// cmd_entry_t in dbg_cmd_pkg is the default-width form of entry_t below.
module dbg_cmd_sysclk_gen
   import dbg_cmd_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int IR_W        = IR_W_DEF,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACTION_BIT  = ACTION_BIT_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       vs_uir,
   input  logic                       vs_udr,
   input  logic [IR_W-1:0]            ir_in,
   input  logic [DATA_W-1:0]          sr,
   input  logic                       cmd_ready,
   input  logic                       ovf_clr,
   output logic [DATA_W-1:0]          jdo,
   output logic                       cmd_valid,
   output logic [(2**IR_W)-1:0]       cmd_sel,
   output logic                       cmd_action,
   output logic                       ir_update,
   output logic [IR_W-1:0]            ir_cur,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
`ifdef DBG_CMD_DROP_CNT_EN
   ,output logic [7:0]                drop_cnt
`endif
);

   localparam int NCH = 2**IR_W;
   localparam int PW  = $clog2(DEPTH);
   localparam int LW  = PW + 1;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] payload;
   } entry_t;

   logic w_uir_rise;
   logic w_udr_rise;

   dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
      .clk     (clk),
      .reset   (reset),
      .i_async (vs_uir),
      .o_rise  (w_uir_rise)
   );

   dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
      .clk     (clk),
      .reset   (reset),
      .i_async (vs_udr),
      .o_rise  (w_udr_rise)
   );

   entry_t            r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_valid;
   logic [DATA_W-1:0] r_jdo;
   logic [NCH-1:0]    r_sel;
   logic [IR_W-1:0]   r_ir_cur;
   logic              r_ir_update;
   logic              r_overflow;

   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   entry_t            w_new;
   logic [PW-1:0]     w_rd_next;
   logic [LW-1:0]     w_level_next;
   entry_t            w_head_next;
   logic [NCH-1:0]    w_sel_next;

   assign w_full       = (r_level == LW'(DEPTH));
   assign w_pop        = r_valid & cmd_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push       = w_udr_rise & (~w_full | w_pop);
   assign w_drop       = w_udr_rise & w_full & ~w_pop;
   // r_ir_cur is the pre-update value, so a coincident update-IR applies to
   // the next command, not this one.
   assign w_new        = {r_ir_cur, sr};
   assign w_rd_next    = r_rd_ptr + PW'(w_pop);
   assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

   // Next head bypasses storage when the incoming entry lands in the slot
   // that becomes head (empty FIFO, or level 1 with a simultaneous pop).
   always_comb begin
      w_head_next = r_mem[w_rd_next];
      if (w_push && (r_wr_ptr == w_rd_next))
         w_head_next = w_new;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_sel
      assign w_sel_next[i] = onehot_ir(int'(w_head_next.ir), i);
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push)
         r_mem[r_wr_ptr] <= w_new;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_valid     <= 1'b0;
         r_jdo       <= '0;
         r_sel       <= '0;
         r_ir_cur    <= '0;
         r_ir_update <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         r_rd_ptr <= w_rd_next;
         r_level  <= w_level_next;
         r_valid  <= (w_level_next != '0);
         if (w_level_next != '0) begin
            r_jdo <= w_head_next.payload;
            r_sel <= w_sel_next;
         end else begin
            r_sel <= '0;
         end
         if (w_uir_rise)
            r_ir_cur <= ir_in;
         r_ir_update <= w_uir_rise;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (ovf_clr)
            r_overflow <= 1'b0;
      end
   end

`ifdef DBG_CMD_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_drop_cnt <= '0;
      else if (ovf_clr)
         r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
      else if (w_drop && (r_drop_cnt != 8'hFF))
         r_drop_cnt <= r_drop_cnt + 8'd1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign jdo        = r_jdo;
   assign cmd_valid  = r_valid;
   assign cmd_sel    = r_sel;
   assign cmd_action = r_valid & r_jdo[ACTION_BIT];
   assign ir_update  = r_ir_update;
   assign ir_cur     = r_ir_cur;
   assign level      = r_level;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_dbg_cmd_sysclk_gen.sv
// tb_dbg_cmd_sysclk_gen
// Directed bench for dbg_cmd_sysclk_gen at default parameters. drop_cnt checks
// are present only when DBG_CMD_DROP_CNT_EN is defined.
module tb_dbg_cmd_sysclk_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs_uir;
   logic        vs_udr;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_ready;
   logic        ovf_clr;
   logic [37:0] jdo;
   logic        cmd_valid;
   logic [3:0]  cmd_sel;
   logic        cmd_action;
   logic        ir_update;
   logic [1:0]  ir_cur;
   logic [2:0]  level;
   logic        overflow;
`ifdef DBG_CMD_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dbg_cmd_sysclk_gen u_dut (
      .clk        (clk),
      .reset      (reset),
      .vs_uir     (vs_uir),
      .vs_udr     (vs_udr),
      .ir_in      (ir_in),
      .sr         (sr),
      .cmd_ready  (cmd_ready),
      .ovf_clr    (ovf_clr),
      .jdo        (jdo),
      .cmd_valid  (cmd_valid),
      .cmd_sel    (cmd_sel),
      .cmd_action (cmd_action),
      .ir_update  (ir_update),
      .ir_cur     (ir_cur),
      .level      (level),
      .overflow   (overflow)
`ifdef DBG_CMD_DROP_CNT_EN
      ,.drop_cnt  (drop_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ctl: 0 plain, 1 cmd_ready on the push edge, 2 ovf_clr on the push edge
   task automatic udr_strobe(input logic [37:0] v, input int ctl);
      sr     = v;
      vs_udr = 1'b1;
      tick();
      tick();
      if (ctl == 1) cmd_ready = 1'b1;
      if (ctl == 2) ovf_clr = 1'b1;
      tick();
      cmd_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick();
      vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pop_one();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      vs_uir    = 1'b0;
      vs_udr    = 1'b0;
      ir_in     = 2'd0;
      sr        = '0;
      cmd_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();

      check("rst_level", level, 0);
      check("rst_valid", cmd_valid, 0);
      check("rst_jdo", jdo, 0);
      check("rst_sel", cmd_sel, 0);
      check("rst_ir_cur", ir_cur, 0);
      check("rst_ir_update", ir_update, 0);
      check("rst_overflow", overflow, 0);

      // First command and its latency
      sr     = 38'h2A_1234_5678;
      vs_udr = 1'b1;
      tick();
      check("lat_k", cmd_valid, 0);
      tick();
      check("lat_k1", cmd_valid, 0);
      tick();
      check("lat_k2", cmd_valid, 1);
      check("c1_jdo", jdo, 38'h2A_1234_5678);
      check("c1_sel", cmd_sel, 4'b0001);
      check("c1_action", cmd_action, 0);
      check("c1_level", level, 1);
      tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      pop_one();
      check("c1_pop_valid", cmd_valid, 0);
      check("c1_pop_level", level, 0);
      check("c1_pop_sel", cmd_sel, 0);
      check("c1_jdo_held", jdo, 38'h2A_1234_5678);

      // IR update then an action command
      ir_in  = 2'd2;
      vs_uir = 1'b1;
      tick();
      tick();
      check("uir_early", ir_update, 0);
      tick();
      check("uir_pulse", ir_update, 1);
      check("uir_ir_cur", ir_cur, 2);
      tick();
      check("uir_pulse_end", ir_update, 0);
      vs_uir = 1'b0;
      repeat (4) tick();
      udr_strobe(38'h04_0000_00AB, 0);
      check("c2_sel", cmd_sel, 4'b0100);
      check("c2_action", cmd_action, 1);
      check("c2_jdo", jdo, 38'h04_0000_00AB);
      pop_one();

      // Five pushes into a depth-4 FIFO
      for (int i = 1; i <= 5; i++) udr_strobe(38'(i), 0);
      check("ovf_level", level, 4);
      check("ovf_flag", overflow, 1);
`ifdef DBG_CMD_DROP_CNT_EN
      check("ovf_drop_cnt", drop_cnt, 1);
`endif
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("b2b_jdo%0d", i), jdo, 64'(i));
         check($sformatf("b2b_valid%0d", i), cmd_valid, 1);
         tick();
      end
      cmd_ready = 1'b0;
      check("b2b_empty", cmd_valid, 0);
      check("b2b_level", level, 0);
      check("ovf_sticky", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", overflow, 0);
`ifdef DBG_CMD_DROP_CNT_EN
      check("ovf_clr_cnt", drop_cnt, 0);
`endif

      // Drop coinciding with ovf_clr: set wins
      for (int i = 21; i <= 24; i++) udr_strobe(38'(i), 0);
      udr_strobe(38'd25, 2);
      check("setwin_ovf", overflow, 1);
      check("setwin_level", level, 4);
`ifdef DBG_CMD_DROP_CNT_EN
      check("setwin_cnt", drop_cnt, 1);
`endif
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;

      // Full FIFO with push and pop on the same edge
      udr_strobe(38'd26, 1);
      check("fullpp_level", level, 4);
      check("fullpp_ovf", overflow, 0);
      cmd_ready = 1'b1;
      check("fullpp_h0", jdo, 22);
      tick();
      check("fullpp_h1", jdo, 23);
      tick();
      check("fullpp_h2", jdo, 24);
      tick();
      check("fullpp_h3", jdo, 26);
      tick();
      cmd_ready = 1'b0;
      check("fullpp_empty", cmd_valid, 0);

      // Reset while holding entries and with vs_udr high
      for (int i = 31; i <= 33; i++) udr_strobe(38'(i), 0);
      check("mid_level3", level, 3);
      sr     = 38'd34;
      vs_udr = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_level", level, 0);
      check("mid_rst_valid", cmd_valid, 0);
      check("mid_rst_ir", ir_cur, 0);
      tick();
      tick();
      reset = 1'b0;
      repeat (8) tick();
      check("post_rst_level", level, 0);
      check("post_rst_valid", cmd_valid, 0);
      vs_udr = 1'b0;
      repeat (4) tick();
      udr_strobe(38'd35, 0);
      check("recover_valid", cmd_valid, 1);
      check("recover_jdo", jdo, 35);
      check("recover_sel", cmd_sel, 4'b0001);
      pop_one();

      // 300 drops, then clear
      for (int i = 41; i <= 44; i++) udr_strobe(38'(i), 0);
      for (int i = 0; i < 300; i++) udr_strobe(38'(100 + i), 0);
      check("sat_level", level, 4);
      check("sat_ovf", overflow, 1);
`ifdef DBG_CMD_DROP_CNT_EN
      check("sat_cnt", drop_cnt, 255);
`endif
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sat_clr_ovf", overflow, 0);
      check("sat_head", jdo, 41);
`ifdef DBG_CMD_DROP_CNT_EN
      check("sat_clr_cnt", drop_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dbg_cmd_sysclk_gen.md
# dbg_cmd_sysclk_gen

Parametrised system-clock-side command receiver for the CPU JTAG debug module. It detects update-IR and update-DR strobes arriving asynchronously from the TCK-domain virtual JTAG, and latches the instruction register and the captured shift register together. Each update-DR is queued as a command in a small FIFO and presented to the OCI core through a valid/ready handshake with one-hot instruction decode. It generalises the fixed 2-bit-IR, 38-bit, single-slot sysclk capture path to arbitrary IR width, data width and queue depth, and adds overflow reporting.

## Interface
- DATA_W, 38: shift-register / command payload width.
- IR_W, 2: instruction register width; 2**IR_W decoded channels.
- DEPTH, 4: command FIFO depth, power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops per strobe, at least 2.
- ACTION_BIT, 34: payload bit that selects action versus no-action.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vs_uir  in  1  TCK-domain update-IR level, asynchronous to clk.
- vs_udr  in  1  TCK-domain update-DR level, asynchronous to clk.
- ir_in  in  IR_W  TCK-domain IR value, quasi-static around vs_uir.
- sr  in  DATA_W  TCK-domain shift register, quasi-static around vs_udr.
- cmd_ready  in  1  consumer accepts the head command.
- ovf_clr  in  1  clears the overflow flag.
- jdo  out  DATA_W  head payload (held when empty).
- cmd_valid  out  1  FIFO non-empty.
- cmd_sel  out  2**IR_W  one-hot of head IR, all zero when cmd_valid is 0.
- cmd_action  out  1  jdo[ACTION_BIT] & cmd_valid.
- ir_update  out  1  one-cycle pulse when the IR latch changes.
- ir_cur  out  IR_W  latched IR.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: at least one command dropped.

## Operation
- Each strobe passes through a SYNC_STAGES flop chain followed by a rising-edge detector (sync_last & ~prev).
- A uir edge latches ir_in into ir_cur and pulses ir_update in the same cycle as the register update.
- A udr edge pushes {ir_cur, sr} into the FIFO.
- If uir and udr edges occur in the same cycle, the pushed entry uses the old ir_cur, then ir_cur updates.
- Pop happens when cmd_valid & cmd_ready. The consumer derives take_action as cmd_action and take_no_action as cmd_valid & ~jdo[ACTION_BIT], both qualified by cmd_ready.
- When the FIFO is full and a push arrives without a pop in the same cycle, the command is dropped, overflow is set, and level is unchanged.
- When the FIFO is full and push and pop occur in the same cycle, both are accepted, level stays DEPTH, and overflow is not set.
- With push and pop on the same cycle at level 1, the new entry becomes head and cmd_valid stays 1.
- overflow clears on ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. level is computed separately and never exceeds DEPTH.
- Reset values: sync chains, prev, pointers, level, ir_cur, jdo, overflow, cmd_valid, cmd_sel and ir_update are all 0.
- Reset mid-operation discards queued commands. A strobe that was high during reset does not produce an edge after release, because prev resets to 0 but the chain is reloaded over SYNC_STAGES cycles before it is compared.

## Timing
- A strobe first sampled high at edge k gives its edge-detect in cycle k+SYNC_STAGES-1. The push registers at edge k+SYNC_STAGES, so cmd_valid, jdo and cmd_sel are visible after edge k+SYNC_STAGES (2 cycles for the default).
- ir_update has the same latency as the push.
- jdo is registered from FIFO storage: first-word-fall-through, zero added latency.
- After a pop, the next head appears on the following cycle.
- Back-to-back pops are sustained at 1 per cycle.
- Strobes must stay high for at least SYNC_STAGES+1 clk cycles and low for at least SYNC_STAGES+1 cycles; TCK no faster than clk/3.

## Configuration
- DBG_CMD_DROP_CNT_EN defined: adds output drop_cnt[7:0], a saturating count of dropped commands.
  - Resets to 0 and clears on ovf_clr.
  - Increments on every drop and holds at 255.
  - If a drop and ovf_clr occur in the same cycle, the result is 1.
- DBG_CMD_DROP_CNT_EN undefined: the port and counter are absent; overflow behaviour is unchanged.

## Structure
- Package dbg_cmd_pkg holds:
  - localparam defaults for DATA_W, IR_W, ACTION_BIT;
  - the cmd_entry_t struct {ir, payload};
  - the function onehot_ir().
- Sub-module dbg_strobe_sync (SYNC_STAGES chain plus edge detect) is instantiated twice.
- The FIFO is kept inline.

## Test plan
- Reset, then hold vs_udr high 5 cycles with sr=38'h2A_1234_5678 and ir_cur=0 -> cmd_valid rises 2 cycles after first sample; jdo=38'h2A_1234_5678; cmd_sel=4'b0001; cmd_action=0.
- vs_uir with ir_in=2, then vs_udr with sr bit 34 set -> ir_update pulse, ir_cur=2; next command has cmd_sel=4'b0100 and cmd_action=1.
- 5 udr strobes with cmd_ready=0 and DEPTH=4 -> level=4, overflow=1, drop_cnt=1; pops return entries 1–4 in order.
- Full FIFO with cmd_ready=1 on the push cycle -> level stays 4 and overflow stays 0.
- Reset asserted while level=3 and vs_udr high -> level=0 and cmd_valid=0; no spurious push after release.
- 300 drops, then ovf_clr -> drop_cnt saturates at 255, then reads 0, and overflow=0.
